imager_roi_crop: RTL and testbench

- Sits directly downstream of the test-pattern imager. Consumes its dat/fv/lv stream.
- Passes a programmable rectangular region of interest (ROI) with 1-cycle registered latency; all pixels outside the ROI are blanked.
- Measures the geometry of each incoming frame and flags malformed frames or an ROI that does not fit.
- Feeds the capture/readout stages that expect a reduced window.

---
 rtl/imager_roi_crop_if.sv | 22 ++
 rtl/imager_roi_crop.sv | 169 ++++++++++++++++
 tb/tb_imager_roi_crop.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imager_roi_crop_if.sv
// Pixel stream bundle for imager_roi_crop: raw imager stream in, cropped stream out.
// master: the side that drives in_* and receives out_*; slave: the crop block.
interface imager_roi_crop_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] in_dat;
  logic                  in_fv;
  logic                  in_lv;
  logic [DATA_WIDTH-1:0] out_dat;
  logic                  out_fv;
  logic                  out_lv;

  modport master (
    output in_dat, in_fv, in_lv,
    input  out_dat, out_fv, out_lv
  );

  modport slave (
    input  in_dat, in_fv, in_lv,
    output out_dat, out_fv, out_lv
  );
endinterface

// File: rtl/imager_roi_crop.sv
// imager_roi_crop: passes a programmable rectangular ROI of the imager stream with
// one cycle of latency, blanks everything else, and measures each frame's geometry.
// Optional build macro IMAGER_ROI_CROP_DECIMATE_EN keeps every other 2x2 Bayer quad
// inside the ROI; when undefined every ROI pixel passes.
module imager_roi_crop #(
  parameter int DATA_WIDTH     = 10,
  parameter int NUM_ROWS_WIDTH = 12,
  parameter int NUM_COLS_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [NUM_ROWS_WIDTH-1:0] roi_row_start,
  input  logic [NUM_ROWS_WIDTH-1:0] roi_rows,
  input  logic [NUM_COLS_WIDTH-1:0] roi_col_start,
  input  logic [NUM_COLS_WIDTH-1:0] roi_cols,
  imager_roi_crop_if.slave          pix,
  output logic [NUM_ROWS_WIDTH-1:0] meas_rows,
  output logic [NUM_COLS_WIDTH-1:0] meas_cols,
  output logic                      meas_valid,
  output logic                      frame_err
);
  localparam int NR = NUM_ROWS_WIDTH;
  localparam int NC = NUM_COLS_WIDTH;
  localparam logic [NR-1:0] ROW_ONE = NR'(1);
  localparam logic [NC-1:0] COL_ONE = NC'(1);

  typedef enum logic [1:0] {ST_ARM, ST_WAIT, ST_FRAME} state_t;
  state_t r_state, w_state_nxt;

  logic [NC-1:0] r_col, r_width, r_cs, r_cols;
  logic [NR-1:0] r_row, r_rs, r_rows;
  logic          r_have_w, r_mism, r_lv_d;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic          r_out_fv, r_out_lv;
  logic [NR-1:0] r_meas_rows;
  logic [NC-1:0] r_meas_cols;
  logic          r_meas_valid, r_frame_err;

  logic          w_start, w_in_frame, w_end, w_active, w_lv_fall;
  logic [NC-1:0] w_col, w_cs, w_cols, w_col_nxt;
  logic [NR-1:0] w_row, w_rs, w_rows, w_row_nxt, w_end_rows;
  logic [NC:0]   w_col_end;
  logic [NR:0]   w_row_end;
  logic          w_hit, w_dec_ok, w_end_err;

  // Frame qualifiers; the fv rising cycle already belongs to the frame so a pixel on it is not lost.
  assign w_start    = enable && (r_state == ST_WAIT)  &&  pix.in_fv;
  assign w_in_frame = enable && (r_state == ST_FRAME) &&  pix.in_fv;
  assign w_end      = enable && (r_state == ST_FRAME) && !pix.in_fv;
  assign w_active   = w_start || w_in_frame;
  assign w_lv_fall  = w_in_frame && r_lv_d && !pix.in_lv;

  // On the start cycle use freshly cleared counters and the live ROI inputs.
  assign w_col  = w_start ? '0 : r_col;
  assign w_row  = w_start ? '0 : r_row;
  assign w_rs   = w_start ? roi_row_start : r_rs;
  assign w_rows = w_start ? roi_rows      : r_rows;
  assign w_cs   = w_start ? roi_col_start : r_cs;
  assign w_cols = w_start ? roi_cols      : r_cols;

  assign w_row_end = {1'b0, w_rs} + {1'b0, w_rows};
  assign w_col_end = {1'b0, w_cs} + {1'b0, w_cols};

`ifdef IMAGER_ROI_CROP_DECIMATE_EN
  logic [NC-1:0] w_col_off;
  logic [NR-1:0] w_row_off;
  assign w_col_off = w_col - w_cs;
  assign w_row_off = w_row - w_rs;
  assign w_dec_ok  = ~w_col_off[1] & ~w_row_off[1];
`else
  assign w_dec_ok  = 1'b1;
`endif

  assign w_hit = w_active && pix.in_lv && w_dec_ok &&
                 (w_row >= w_rs) && ({1'b0, w_row} < w_row_end) &&
                 (w_col >= w_cs) && ({1'b0, w_col} < w_col_end);

  // An unterminated last line still counts as a row and marks the frame malformed.
  assign w_end_rows = (r_lv_d && !(&r_row)) ? r_row + ROW_ONE : r_row;
  assign w_end_err  = r_mism || r_lv_d ||
                      (({1'b0, r_rs} + {1'b0, r_rows}) > {1'b0, w_end_rows}) ||
                      (({1'b0, r_cs} + {1'b0, r_cols}) > {1'b0, r_width});

  // Saturating next values of the column and row counters.
  always_comb begin
    w_col_nxt = w_col;
    w_row_nxt = w_row;
    if (pix.in_lv) begin
      if (!(&w_col)) w_col_nxt = w_col + COL_ONE;
    end else if (w_lv_fall) begin
      w_col_nxt = '0;
      if (!(&w_row)) w_row_nxt = w_row + ROW_ONE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ARM;
    else          r_state <= w_state_nxt;
  end

  // Next state: arm on fv low, open a frame on fv rise, close it on fv fall.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_ARM;
    end else begin
      case (r_state)
        ST_ARM:   if (!pix.in_fv) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (pix.in_fv)  w_state_nxt = ST_FRAME;
        ST_FRAME: if (!pix.in_fv) w_state_nxt = ST_WAIT;
        default:  w_state_nxt = ST_ARM;
      endcase
    end
  end

  // Counters, ROI shadow, line-width tracking, output and measurement registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0; r_row <= '0; r_width <= '0; r_have_w <= 1'b0; r_mism <= 1'b0; r_lv_d <= 1'b0;
      r_rs <= '0; r_rows <= '0; r_cs <= '0; r_cols <= '0;
      r_out_dat <= '0; r_out_fv <= 1'b0; r_out_lv <= 1'b0;
      r_meas_rows <= '0; r_meas_cols <= '0; r_meas_valid <= 1'b0; r_frame_err <= 1'b0;
    end else if (!enable) begin
      r_col <= '0; r_row <= '0; r_lv_d <= 1'b0;
      r_out_dat <= '0; r_out_fv <= 1'b0; r_out_lv <= 1'b0;
      r_meas_valid <= 1'b0;
    end else begin
      r_lv_d       <= pix.in_lv;
      r_out_fv     <= w_active;
      r_out_lv     <= w_hit;
      r_out_dat    <= w_hit ? pix.in_dat : '0;
      r_meas_valid <= w_end;
      if (w_start) begin
        r_rs <= roi_row_start; r_rows <= roi_rows;
        r_cs <= roi_col_start; r_cols <= roi_cols;
        r_width <= '0; r_have_w <= 1'b0; r_mism <= 1'b0;
      end
      if (w_active) begin
        r_col <= w_col_nxt;
        r_row <= w_row_nxt;
      end
      if (w_lv_fall) begin
        if (!r_have_w) begin
          r_width  <= r_col;
          r_have_w <= 1'b1;
        end else if (r_col != r_width) begin
          r_mism <= 1'b1;
        end
      end
      if (w_end) begin
        r_meas_rows <= w_end_rows;
        r_meas_cols <= r_width;
        r_frame_err <= w_end_err;
        r_col <= '0;
        r_row <= '0;
      end
    end
  end

  assign pix.out_dat = r_out_dat;
  assign pix.out_fv  = r_out_fv;
  assign pix.out_lv  = r_out_lv;
  assign meas_rows   = r_meas_rows;
  assign meas_cols   = r_meas_cols;
  assign meas_valid  = r_meas_valid;
  assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_imager_roi_crop.sv
// Scoreboard bench for imager_roi_crop: the stimulus pushes expected ROI pixels and
// frame measurements into queues; a negedge monitor pops and compares them.
module tb_imager_roi_crop;
  localparam int DW = 10;
  localparam int NR = 12;
  localparam int NC = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic enable = 1'b0;
  logic [NR-1:0] roi_row_start = '0;
  logic [NR-1:0] roi_rows = '0;
  logic [NC-1:0] roi_col_start = '0;
  logic [NC-1:0] roi_cols = '0;
  logic [NR-1:0] meas_rows;
  logic [NC-1:0] meas_cols;
  logic          meas_valid, frame_err;

  imager_roi_crop_if #(.DATA_WIDTH(DW)) pix ();

  imager_roi_crop #(
    .DATA_WIDTH(DW),
    .NUM_ROWS_WIDTH(NR),
    .NUM_COLS_WIDTH(NC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .roi_row_start(roi_row_start),
    .roi_rows(roi_rows),
    .roi_col_start(roi_col_start),
    .roi_cols(roi_cols),
    .pix(pix),
    .meas_rows(meas_rows),
    .meas_cols(meas_cols),
    .meas_valid(meas_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rows;
    int cols;
    int err;
    int fvc;
  } meas_t;

  meas_t mq[$];
  int    pq[$];
  int    checks = 0;
  int    errors = 0;
  int    fv_cnt = 0;
  int    fnum   = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  function automatic bit in_roi(int r, int c, int rs, int rows, int cs, int cols);
    bit h;
    h = (r >= rs) && (r < rs + rows) && (c >= cs) && (c < cs + cols);
`ifdef IMAGER_ROI_CROP_DECIMATE_EN
    if ((((r - rs) & 2) != 0) || (((c - cs) & 2) != 0)) h = 1'b0;
`endif
    return h;
  endfunction

  task automatic drive(input bit fv, input bit lv, input int dat);
    @(posedge clk);
    #1;
    pix.in_fv  = fv;
    pix.in_lv  = lv;
    pix.in_dat = DW'(dat);
  endtask

  task automatic gap(input int n);
    repeat (n) drive(1'b0, 1'b0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_fv"},     int'(pix.out_fv), 0);
    chk({tag, "_out_lv"},     int'(pix.out_lv), 0);
    chk({tag, "_out_dat"},    int'(pix.out_dat), 0);
    chk({tag, "_meas_rows"},  int'(meas_rows), 0);
    chk({tag, "_meas_cols"},  int'(meas_cols), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_frame_err"},  int'(frame_err), 0);
  endtask

  // One frame: 1 lead cycle, nrows lines of ncols pixels + 4 blank cycles, then fv low.
  task automatic run_frame(input int nrows, input int ncols, input int short_row,
                           input int en_row, input int chg_row, input int chg_cols,
                           input int rst_row, input bit exp_out,
                           input int ers, input int erows, input int ecs, input int ecols,
                           input bit exp_meas, input int mrows, input int mcols, input int merr);
    int fvc;
    int d;
    int w;
    drive(1'b1, 1'b0, 0);
    fvc = 1;
    for (int r = 0; r < nrows; r++) begin
      w = (r == short_row) ? ncols - 1 : ncols;
      if (r == en_row)  enable = 1'b1;
      if (r == chg_row) roi_cols = NC'(chg_cols);
      for (int c = 0; c < w; c++) begin
        d = ((fnum & 7) << 7) | (r << 4) | c;
        drive(1'b1, 1'b1, d);
        fvc++;
        if (exp_out && in_roi(r, c, ers, erows, ecs, ecols)) pq.push_back(d);
        if (r == rst_row && c == 3) begin
          #2 reset_n = 1'b0;
          #1 chk_all_zero("rst_async");
          #2 reset_n = 1'b1;
        end
      end
      repeat (4) begin
        drive(1'b1, 1'b0, 0);
        fvc++;
      end
    end
    drive(1'b0, 1'b0, 0);
    if (exp_meas) mq.push_back('{mrows, mcols, merr, fvc});
    gap(23);
    fnum++;
  endtask

  // Monitor: pixels while out_lv, blanking otherwise, measurements on meas_valid.
  always @(negedge clk) begin
    if (!reset_n) begin
      fv_cnt = 0;
    end else begin
      meas_t m;
      int    p;
      if (pix.out_fv) fv_cnt++;
      if (pix.out_lv) begin
        chk("pix_pending", int'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          p = pq.pop_front();
          chk("pix_dat", int'(pix.out_dat), p);
        end
      end else begin
        chk("dat_blank", int'(pix.out_dat), 0);
      end
      if (meas_valid) begin
        chk("meas_pending", int'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          m = mq.pop_front();
          chk("meas_rows", int'(meas_rows), m.rows);
          chk("meas_cols", int'(meas_cols), m.cols);
          chk("frame_err", int'(frame_err), m.err);
          chk("fv_cycles", fv_cnt, m.fvc);
        end
        fv_cnt = 0;
      end
    end
  end

  initial begin
    pix.in_fv  = 1'b0;
    pix.in_lv  = 1'b0;
    pix.in_dat = '0;
    #3 reset_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;
    roi_row_start = NR'(1); roi_rows = NR'(3);
    roi_col_start = NC'(2); roi_cols = NC'(4);
    gap(5);

    // Nominal crop: 3 lines of columns 2..5.
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 0);
    // ROI overhangs the right edge: columns 6..7 only, error flagged.
    roi_col_start = NC'(6);
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 6, 4, 1'b1, 6, 8, 1);
    // Async reset mid-line; rest of this frame produces nothing.
    run_frame(6, 8, -1, -1, -1, 0, 1, 1'b0, 1, 3, 6, 4, 1'b0, 0, 0, 0);
    roi_col_start = NC'(2);
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 0);
    // Short line on row 2, then recovery.
    run_frame(6, 8, 2, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 1);
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 0);
    // ROI width changed mid-frame takes effect on the next frame only.
    run_frame(6, 8, -1, -1, 2, 2, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 0);
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 2, 1'b1, 6, 8, 0);
    // Zero-height ROI: no pixels, frame timing still passes.
    roi_rows = '0;
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 0, 2, 2, 1'b1, 6, 8, 0);
    // Enable raised mid-frame: silent until the next full frame.
    roi_rows = NR'(3); roi_cols = NC'(4);
    enable = 1'b0;
    gap(2);
    run_frame(6, 8, -1, 3, -1, 0, -1, 1'b0, 1, 3, 2, 4, 1'b0, 0, 0, 0);
    run_frame(6, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 6, 8, 0);
    // Frame with no lines at all.
    run_frame(0, 8, -1, -1, -1, 0, -1, 1'b1, 1, 3, 2, 4, 1'b1, 0, 0, 1);
`ifdef IMAGER_ROI_CROP_DECIMATE_EN
    roi_row_start = '0; roi_rows = NR'(8);
    roi_col_start = '0; roi_cols = NC'(8);
    run_frame(8, 8, -1, -1, -1, 0, -1, 1'b1, 0, 8, 0, 8, 1'b1, 8, 8, 0);
`endif
    gap(10);
    chk("pix_left",  pq.size(), 0);
    chk("meas_left", mq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
